// File: rtl/vga_pkg.sv
// Shared 800x600@60 Hz timing constants and the 11-bit count type used by the
// timing generator and by the downstream sprite/ROM stages.
package vga_pkg;

  localparam int CNT_W  = 11;

  localparam int H_VIS  = 800;
  localparam int H_FP   = 40;
  localparam int H_SYNC = 128;
  localparam int H_BP   = 88;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS  = 600;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 4;
  localparam int V_BP   = 23;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_POL = 1'b1;

  typedef logic [CNT_W-1:0] vcnt_t;

endpackage

// File: rtl/vga_axis_ctr.sv
// One timing axis: wrapping counter with blank/sync/wrap flags registered from the
// next count, so every flag lines up with cnt in the same cycle.
module vga_axis_ctr
  import vga_pkg::*;
#(
  parameter int   VIS  = H_VIS,
  parameter int   FP   = H_FP,
  parameter int   SYNC = H_SYNC,
  parameter int   BP   = H_BP,
  parameter logic POL  = SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             blnk,
  output logic             sync,
  output logic             wrap
);

  localparam int    TOT     = VIS + FP + SYNC + BP;
  localparam vcnt_t LAST    = vcnt_t'(TOT - 1);
  localparam vcnt_t VIS_C   = vcnt_t'(VIS);
  localparam vcnt_t SYNC_LO = vcnt_t'(VIS + FP);
  localparam vcnt_t SYNC_HI = vcnt_t'(VIS + FP + SYNC);

  generate
    if (TOT > (1 << CNT_W)) begin : g_tot_chk
      $error("vga_axis_ctr: axis total does not fit the count width");
    end
  endgenerate

  vcnt_t cnt_nxt;
  logic  in_sync;

  always_comb begin
    cnt_nxt = cnt;
    if (inc) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + vcnt_t'(1);
    end
    in_sync = (cnt_nxt >= SYNC_LO) && (cnt_nxt < SYNC_HI);
  end

  // Unconditional reload from cnt_nxt keeps the flags a pure function of cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      blnk <= 1'b0;
      sync <= ~POL;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      blnk <= (cnt_nxt >= VIS_C);
      sync <= in_sync ? POL : ~POL;
      wrap <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: h/v counters, sync/blank flags, frame strobe and
// frame counter, all registered; en=0 freezes everything and masks frame_start.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   P_H_VIS    = H_VIS,
  parameter int   P_H_FP     = H_FP,
  parameter int   P_H_SYNC   = H_SYNC,
  parameter int   P_H_BP     = H_BP,
  parameter int   P_V_VIS    = V_VIS,
  parameter int   P_V_FP     = V_FP,
  parameter int   P_V_SYNC   = V_SYNC,
  parameter int   P_V_BP     = V_BP,
  parameter logic P_SYNC_POL = SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);

  logic h_wrap;
  logic v_wrap;
  logic v_inc;
  logic frame_inc;

  assign v_inc     = h_wrap & en;
  assign frame_inc = v_wrap & h_wrap & en;

  vga_axis_ctr #(
    .VIS (P_H_VIS),
    .FP  (P_H_FP),
    .SYNC(P_H_SYNC),
    .BP  (P_H_BP),
    .POL (P_SYNC_POL)
  ) u_h (
    .clk (clk),
    .rst (rst),
    .inc (en),
    .cnt (hcount),
    .blnk(hblnk),
    .sync(hsync),
    .wrap(h_wrap)
  );

  vga_axis_ctr #(
    .VIS (P_V_VIS),
    .FP  (P_V_FP),
    .SYNC(P_V_SYNC),
    .BP  (P_V_BP),
    .POL (P_SYNC_POL)
  ) u_v (
    .clk (clk),
    .rst (rst),
    .inc (v_inc),
    .cnt (vcount),
    .blnk(vblnk),
    .sync(vsync),
    .wrap(v_wrap)
  );

  logic [15:0] frame_cnt_nxt;

  assign frame_cnt_nxt = frame_cnt + {15'd0, frame_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= frame_inc;
      frame_cnt   <= frame_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; frame-level scenarios jump the vertical
// counter (and frame counter) with hierarchical force to keep the run short.
module tb_vga_timing_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        frame_start;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  vga_timing_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync      (hsync),
    .vsync      (vsync),
    .hblnk      (hblnk),
    .vblnk      (vblnk),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start}
  function automatic logic [26:0] pack_exp(int h, int v, logic fs);
    logic [10:0] hh;
    logic [10:0] vv;
    hh = h[10:0];
    vv = v[10:0];
    return {hh, vv, logic'(h >= 840 && h < 968), logic'(v >= 601 && v < 605),
            logic'(h >= 800), logic'(v >= 600), fs};
  endfunction

  function automatic logic [26:0] pack_obs();
    return {hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    tick();
    tick();
    total++;
    if ({hcount, vcount} !== 22'd0) begin
      bad++;
      $display("FAIL reset_counts: got h=%0d v=%0d want 0 0", hcount, vcount);
    end
    total++;
    if ({hsync, vsync, hblnk, vblnk, frame_start} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_flags: got hs=%b vs=%b hb=%b vb=%b fs=%b want all 0",
               hsync, vsync, hblnk, vblnk, frame_start);
    end
    total++;
    if (frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_line();
    logic [26:0] exp;
    for (int i = 0; i < 1056; i++) begin
      exp = pack_exp(i, 0, 1'b0);
      total++;
      if (pack_obs() !== exp) begin
        bad++;
        $display("FAIL line_decode: step %0d got %h want %h", i, pack_obs(), exp);
      end
      tick();
    end
    total++;
    if ({hcount, vcount, frame_start} !== {11'd0, 11'd1, 1'b0}) begin
      bad++;
      $display("FAIL line_wrap: got h=%0d v=%0d fs=%b want 0 1 0", hcount, vcount, frame_start);
    end
  endtask

  task automatic test_frame();
    logic [26:0] exp;
    int eh;
    int ev;
    int pulses;
    force dut.u_v.cnt = 11'd598;
    tick();
    release dut.u_v.cnt;
    eh = 1;
    ev = 598;
    pulses = 0;
    total++;
    if ({hcount, vcount} !== {11'd1, 11'd598}) begin
      bad++;
      $display("FAIL frame_jump: got h=%0d v=%0d want 1 598", hcount, vcount);
    end
    for (int n = 0; n < 31679; n++) begin
      tick();
      eh++;
      if (eh == 1056) begin
        eh = 0;
        ev++;
        if (ev == 628) ev = 0;
      end
      if (frame_start === 1'b1) pulses++;
      exp = pack_exp(eh, ev, logic'(eh == 0 && ev == 0));
      total++;
      if (pack_obs() !== exp) begin
        bad++;
        $display("FAIL frame_decode: h=%0d v=%0d got %h want %h", eh, ev, pack_obs(), exp);
      end
    end
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL frame_pulse_count: got %0d want 1", pulses);
    end
    total++;
    if (frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL frame_cnt_inc: got %0d want 1", frame_cnt);
    end
  endtask

  task automatic test_enable();
    logic [26:0] held;
    logic [15:0] held_cnt;
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({hcount, vcount, frame_start, frame_cnt} !== {11'd0, 11'd0, 1'b0, 16'd1}) begin
        bad++;
        $display("FAIL frozen_origin: got h=%0d v=%0d fs=%b fc=%0d want 0 0 0 1",
                 hcount, vcount, frame_start, frame_cnt);
      end
    end
    en = 1'b1;
    repeat (10 * 1056 + 500) tick();
    total++;
    if ({hcount, vcount} !== {11'd500, 11'd10}) begin
      bad++;
      $display("FAIL en_reach: got h=%0d v=%0d want 500 10", hcount, vcount);
    end
    held     = pack_exp(500, 10, 1'b0);
    held_cnt = 16'd1;
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      total++;
      if ({pack_obs(), frame_cnt} !== {held, held_cnt}) begin
        bad++;
        $display("FAIL en_hold: cycle %0d got %h/%0d want %h/%0d",
                 i, pack_obs(), frame_cnt, held, held_cnt);
      end
    end
    en = 1'b1;
    tick();
    total++;
    if ({hcount, vcount} !== {11'd501, 11'd10}) begin
      bad++;
      $display("FAIL en_resume: got h=%0d v=%0d want 501 10", hcount, vcount);
    end
  endtask

  task automatic test_mid_reset();
    repeat (399) tick();
    total++;
    if ({hcount, hsync} !== {11'd900, 1'b1}) begin
      bad++;
      $display("FAIL pre_reset_sync: got h=%0d hs=%b want 900 1", hcount, hsync);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({hcount, vcount, hsync, frame_cnt} !== {11'd0, 11'd0, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL mid_reset: got h=%0d v=%0d hs=%b fc=%0d want 0 0 0 0",
               hcount, vcount, hsync, frame_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_cnt_wrap();
    force dut.frame_cnt = 16'hFFFF;
    force dut.u_v.cnt   = 11'd627;
    tick();
    release dut.frame_cnt;
    release dut.u_v.cnt;
    repeat (1054) tick();
    total++;
    if ({hcount, vcount, frame_start, frame_cnt} !== {11'd1055, 11'd627, 1'b0, 16'hFFFF}) begin
      bad++;
      $display("FAIL pre_wrap: got h=%0d v=%0d fs=%b fc=%h want 1055 627 0 ffff",
               hcount, vcount, frame_start, frame_cnt);
    end
    tick();
    total++;
    if ({hcount, vcount, frame_start, frame_cnt} !== {11'd0, 11'd0, 1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL frame_cnt_wrap: got h=%0d v=%0d fs=%b fc=%h want 0 0 1 0000",
               hcount, vcount, frame_start, frame_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_enable();
    test_mid_reset();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
